uart_alu_sequencer: RTL and testbench
=====================================

# uart_alu_sequencer

Frame sequencer between the UART receive FIFO, the combinational ALU and the UART transmit FIFO. It pops three bytes from the RX FIFO (operand A, operand B, opcode) and presents them to the ALU. It then captures the ALU result and pushes it into the TX FIFO, so a host PC can drive the ALU over the serial link. An inter-byte timeout discards partial frames.

## Interface
Parameters:
- DB, 8, data width of UART bytes, ALU operands, opcode and result
- TIMEOUT_CYC, 50_000_000, max idle cycles allowed between bytes of one frame; 0 disables the timeout

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- rx_empty  in  1  RX FIFO empty flag; r_data valid whenever low
- r_data  in  DB  RX FIFO head byte
- rd  out  1  RX FIFO pop, registered one-cycle pulse
- tx_full  in  1  TX FIFO full flag
- w_data  out  DB  byte to TX FIFO
- wr  out  1  TX FIFO push, registered one-cycle pulse
- alu_a  out  DB  operand A register
- alu_b  out  DB  operand B register
- alu_op  out  DB  opcode register
- alu_result  in  DB  combinational ALU result
- busy  out  1  high from acceptance of byte A until the result is pushed or the frame is aborted
- done  out  1  one-cycle pulse, coincident with wr
- frame_err  out  1  one-cycle pulse on timeout abort

## Operation
- States: GET_A, GET_B, GET_OP, EXEC, SEND. The reset state is GET_A.
- Accept condition, valid in GET_A, GET_B and GET_OP: rx_empty==0 && rd==0. The rd==0 term guards against double-pop while the FIFO flag updates.
- GET_A: on accept, alu_a<=r_data, rd<=1, busy<=1, go to GET_B.
- GET_B: on accept, alu_b<=r_data, rd<=1, go to GET_OP.
- GET_OP: on accept, alu_op<=r_data, rd<=1, go to EXEC.
- EXEC: result register<=alu_result, go to SEND. Exactly one cycle.
- SEND: if tx_full==0: w_data<=result, wr<=1, done<=1, busy<=0, go to GET_A. Otherwise stay in SEND and hold all outputs.
- alu_a, alu_b and alu_op hold their values after the frame until overwritten by the next frame.
- Timeout: the counter runs only in GET_B and GET_OP. It increments each cycle with no accept and clears on every accept and every state change.
  - When the count reaches TIMEOUT_CYC: go to GET_A, frame_err<=1, busy<=0, operand registers unchanged.
  - The byte accepted on the same edge wins over the timeout.
  - Counter width is $clog2(TIMEOUT_CYC+1). With TIMEOUT_CYC==0, no timeout logic is generated.
- There is no timeout in GET_A (waiting for a frame start) or in SEND (back-pressure waits indefinitely).
- Reset, asynchronous and mid-frame: the state returns to GET_A and every output and internal register goes to 0: rd, wr, w_data, alu_a, alu_b, alu_op, result, busy, done, frame_err and the counter. Partial frames are lost; no FIFO access occurs during reset.

## Timing
- rd, wr, done and frame_err are high for exactly one cycle, following the edge that decided them.
- Minimum spacing between accepts is 2 cycles, because of the rd guard.
- Latency with tx_full low: accept of OP at edge k, EXEC at edge k+1, SEND decides wr at edge k+2. wr is high during cycle k+2..k+3.
- Minimum frame period with a full RX FIFO is 7 cycles: 3 accepts at 2-cycle spacing, then EXEC, then SEND.
- alu_result is sampled one cycle after alu_op updates, which leaves one full cycle for ALU propagation.

## Structure
- Shared package uart_alu_pkg holds:
  - state encoding localparams (3 bits): GET_A=0, GET_B=1, GET_OP=2, EXEC=3, SEND=4
  - the default DB
  - byte-order constants (index of A, B, OP within a frame)
- Sub-module frame_timer holds the parameterised timeout counter. Inputs: clk, rst_n, run, clear. Output: expired.
- Sequencer FSM: one registered-state always block plus one next-state block. Registered outputs only.

## Test plan
- Reset: hold rst_n=0 with rx_empty=0 -> rd, wr and all data outputs are 0, and no pop occurs. Release -> the first rd pulse lands one edge later.
- Basic frame: preload the RX FIFO with 0x05, 0x03, 0x20 and an ADD ALU model -> alu_a=0x05, alu_b=0x03, alu_op=0x20. Then a single wr with w_data=0x08, done is coincident, and exactly three rd pulses occur.
- Back-pressure: tx_full=1 during SEND for 10 cycles, then 0 -> no wr while full. wr fires on the first edge after tx_full falls, with w_data unchanged.
- Timeout: TIMEOUT_CYC=16, send 0x11 then nothing -> frame_err pulses 16 cycles after the GET_B entry and the state returns to GET_A. A following frame 0x02, 0x02, ADD yields w_data=0x04.
- Byte at timeout edge: deliver B exactly on the expiry edge -> the byte is accepted, no frame_err, and the frame completes.
- Reset mid-frame: assert rst_n=0 in GET_OP, release, then send a full new frame -> the result is computed only from the new bytes, with no stray wr.

Source files
------------

// File: rtl/uart_alu_pkg.sv
// Shared constants for the UART/ALU frame sequencer: state encoding,
// default byte width and the byte order of a host frame.
package uart_alu_pkg;

    localparam int DB_DEF = 8;

    typedef logic [2:0] state_t;

    localparam state_t ST_GET_A  = 3'd0;
    localparam state_t ST_GET_B  = 3'd1;
    localparam state_t ST_GET_OP = 3'd2;
    localparam state_t ST_EXEC   = 3'd3;
    localparam state_t ST_SEND   = 3'd4;

    // Byte position within a frame; matches the GET_* state that captures it.
    localparam int IDX_A     = 0;
    localparam int IDX_B     = 1;
    localparam int IDX_OP    = 2;
    localparam int FRAME_LEN = 3;

    function automatic logic is_get_state(input state_t s);
        return (s == ST_GET_A) || (s == ST_GET_B) || (s == ST_GET_OP);
    endfunction

endpackage

// File: rtl/uart_alu_sequencer_frame_timer.sv
// Inter-byte idle counter. expired is a same-cycle decision so the FSM can
// abort on the edge the count reaches TIMEOUT_CYC; a clear on that edge wins.
module frame_timer #(
    parameter int TIMEOUT_CYC = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic clear,
    output logic expired
);

    generate
        if (TIMEOUT_CYC == 0) begin : g_off
            logic unused_tmr;
            assign unused_tmr = ^{clk, rst_n, run, clear};
            assign expired    = 1'b0;
        end else begin : g_on
            localparam int             CW    = $clog2(TIMEOUT_CYC + 1);
            localparam logic [CW-1:0]  LIMIT = CW'(TIMEOUT_CYC - 1);

            logic [CW-1:0] cnt_q, cnt_d;

            assign expired = run && !clear && (cnt_q == LIMIT);

            always_comb begin
                cnt_d = cnt_q + 1'b1;
                if (!run || clear || expired)
                    cnt_d = '0;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) cnt_q <= '0;
                else        cnt_q <= cnt_d;
            end
        end
    endgenerate

endmodule

// File: rtl/uart_alu_sequencer.sv
// Pops A, B, opcode from the RX FIFO, drives the ALU, captures its result one
// cycle later and pushes it to the TX FIFO. All outputs are registered.
module uart_alu_sequencer
    import uart_alu_pkg::*;
#(
    parameter int DB          = DB_DEF,
    parameter int TIMEOUT_CYC = 50_000_000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rx_empty,
    input  logic [DB-1:0] r_data,
    output logic          rd,
    input  logic          tx_full,
    output logic [DB-1:0] w_data,
    output logic          wr,
    output logic [DB-1:0] alu_a,
    output logic [DB-1:0] alu_b,
    output logic [DB-1:0] alu_op,
    input  logic [DB-1:0] alu_result,
    output logic          busy,
    output logic          done,
    output logic          frame_err
);

    state_t                         state_q, state_d;
    logic [FRAME_LEN-1:0][DB-1:0]   opnd_q, opnd_d;
    logic [DB-1:0]                  result_q, result_d;
    logic [DB-1:0]                  w_data_q, w_data_d;
    logic                           rd_q, rd_d;
    logic                           wr_q, wr_d;
    logic                           busy_q, busy_d;
    logic                           done_q, done_d;
    logic                           ferr_q, ferr_d;

    logic accept, tmr_run, tmr_exp;

    // rd_q blocks a second pop while the FIFO flag catches up.
    assign accept  = is_get_state(state_q) && !rx_empty && !rd_q;
    assign tmr_run = (state_q == ST_GET_B) || (state_q == ST_GET_OP);

    frame_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .run     (tmr_run),
        .clear   (accept),
        .expired (tmr_exp)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_GET_A:  if (accept) state_d = ST_GET_B;
            ST_GET_B:  if (accept) state_d = ST_GET_OP;
                       else if (tmr_exp) state_d = ST_GET_A;
            ST_GET_OP: if (accept) state_d = ST_EXEC;
                       else if (tmr_exp) state_d = ST_GET_A;
            ST_EXEC:   state_d = ST_SEND;
            ST_SEND:   if (!tx_full) state_d = ST_GET_A;
            default:   state_d = ST_GET_A;
        endcase
    end

    always_comb begin
        opnd_d   = opnd_q;
        result_d = result_q;
        w_data_d = w_data_q;
        busy_d   = busy_q;
        rd_d     = 1'b0;
        wr_d     = 1'b0;
        done_d   = 1'b0;
        ferr_d   = 1'b0;

        if (accept) begin
            for (int i = 0; i < FRAME_LEN; i++)
                if (state_q == state_t'(i)) opnd_d[i] = r_data;
            rd_d = 1'b1;
            if (state_q == ST_GET_A) busy_d = 1'b1;
        end else if (tmr_exp) begin
            ferr_d = 1'b1;
            busy_d = 1'b0;
        end

        if (state_q == ST_EXEC) result_d = alu_result;

        if (state_q == ST_SEND && !tx_full) begin
            w_data_d = result_q;
            wr_d     = 1'b1;
            done_d   = 1'b1;
            busy_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_GET_A;
            opnd_q   <= '0;
            result_q <= '0;
            w_data_q <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            opnd_q   <= opnd_d;
            result_q <= result_d;
            w_data_q <= w_data_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            ferr_q   <= ferr_d;
        end
    end

    assign rd        = rd_q;
    assign wr        = wr_q;
    assign w_data    = w_data_q;
    assign alu_a     = opnd_q[IDX_A];
    assign alu_b     = opnd_q[IDX_B];
    assign alu_op    = opnd_q[IDX_OP];
    assign busy      = busy_q;
    assign done      = done_q;
    assign frame_err = ferr_q;

endmodule

// File: tb/tb_uart_alu_sequencer.sv
// Bench for uart_alu_sequencer: queue-based RX/TX FIFO models, a small ALU,
// directed corner cases and randomized frames with random TX back-pressure.
module tb_uart_alu_sequencer;

    localparam int DB = 8;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rx_empty = 1'b1;
    logic [DB-1:0] r_data = '0;
    logic          tx_full = 1'b0;
    logic          rd, wr, busy, done, frame_err;
    logic [DB-1:0] w_data, alu_a, alu_b, alu_op, alu_result;

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                           input logic [7:0] op);
        case (op)
            8'h20:   return a + b;
            8'h21:   return a - b;
            8'h22:   return a & b;
            8'h23:   return a ^ b;
            default: return a | b;
        endcase
    endfunction

    assign alu_result = alu_ref(alu_a, alu_b, alu_op);

    uart_alu_sequencer #(.DB(DB), .TIMEOUT_CYC(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_empty   (rx_empty),
        .r_data     (r_data),
        .rd         (rd),
        .tx_full    (tx_full),
        .w_data     (w_data),
        .wr         (wr),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .busy       (busy),
        .done       (done),
        .frame_err  (frame_err)
    );

    int n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [7:0] rxq[$];
    logic [7:0] outq[$];
    logic [7:0] expq[$];
    int cyc = 0, rd_cnt = 0, wr_cnt = 0, ferr_cnt = 0;
    int last_rd_cyc = 0, last_wr_cyc = 0, last_ferr_cyc = 0;
    bit rand_bp = 0;

    task automatic refresh();
        rx_empty = (rxq.size() == 0);
        r_data   = (rxq.size() > 0) ? rxq[0] : 8'h00;
    endtask

    task automatic push_byte(input logic [7:0] b);
        rxq.push_back(b);
        refresh();
    endtask

    // One clock of the environment: FIFO pop, TX capture, pulse bookkeeping.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (rd) begin
            rd_cnt++;
            last_rd_cyc = cyc;
            if (rxq.size() > 0) void'(rxq.pop_front());
        end
        if (wr) begin
            wr_cnt++;
            last_wr_cyc = cyc;
            outq.push_back(w_data);
        end
        if (wr || done) chk("done_with_wr", {31'b0, done}, {31'b0, wr});
        if (frame_err) begin
            ferr_cnt++;
            last_ferr_cyc = cyc;
        end
        if (rand_bp) tx_full = ($urandom_range(0, 3) == 0);
        refresh();
    endtask

    task automatic wait_out(input int n, input int budget);
        for (int i = 0; i < budget && outq.size() < n; i++) tick();
        chk("wait_out", outq.size(), n);
    endtask

    task automatic wait_rd(input int n, input int budget);
        for (int i = 0; i < budget && rd_cnt < n; i++) tick();
        chk("wait_rd", rd_cnt, n);
    endtask

    task automatic push_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
        push_byte(a);
        push_byte(b);
        push_byte(op);
    endtask

    initial begin
        int t0, t_a, w0, f0, r0;
        logic [7:0] got;

        // Reset with data waiting: nothing may move
        push_frame(8'h05, 8'h03, 8'h20);
        repeat (4) tick();
        chk("rst_rd", rd, 0);
        chk("rst_wr", wr, 0);
        chk("rst_w_data", w_data, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_alu_op", alu_op, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done_ferr", {done, frame_err}, 0);
        chk("rst_no_pop", rd_cnt, 0);

        // Basic frame and minimum frame period
        rst_n = 1'b1;
        t0 = cyc;
        tick();
        chk("first_rd", rd, 1);
        wait_out(1, 40);
        chk("basic_alu_a", alu_a, 8'h05);
        chk("basic_alu_b", alu_b, 8'h03);
        chk("basic_alu_op", alu_op, 8'h20);
        chk("basic_latency", last_wr_cyc - t0, 7);
        repeat (5) tick();
        chk("basic_rd_cnt", rd_cnt, 3);
        chk("basic_wr_cnt", wr_cnt, 1);
        chk("basic_busy_idle", busy, 0);
        got = outq.pop_front();
        chk("basic_result", got, 8'h08);

        // Back-pressure in SEND
        tx_full = 1'b1;
        w0 = wr_cnt;
        push_frame(8'h10, 8'h20, 8'h21);
        repeat (16) tick();
        chk("bp_no_wr", wr_cnt, w0);
        chk("bp_busy", busy, 1);
        tx_full = 1'b0;
        tick();
        chk("bp_wr_first_edge", wr, 1);
        chk("bp_w_data", w_data, 8'hF0);
        void'(outq.pop_front());

        // Timeout after byte A only
        f0 = ferr_cnt;
        r0 = rd_cnt;
        push_byte(8'h11);
        wait_rd(r0 + 1, 10);
        t_a = last_rd_cyc;
        for (int i = 0; i < 30 && ferr_cnt == f0; i++) tick();
        chk("to_ferr_cnt", ferr_cnt, f0 + 1);
        chk("to_delay", last_ferr_cyc - t_a, TO);
        chk("to_busy", busy, 0);
        chk("to_keep_a", alu_a, 8'h11);
        chk("to_keep_b", alu_b, 8'h20);
        push_frame(8'h02, 8'h02, 8'h20);
        wait_out(1, 40);
        got = outq.pop_front();
        chk("to_next_frame", got, 8'h04);

        // Byte B lands exactly on the expiry edge
        f0 = ferr_cnt;
        r0 = rd_cnt;
        push_byte(8'h07);
        wait_rd(r0 + 1, 10);
        t_a = last_rd_cyc;
        while (cyc < t_a + TO - 1) tick();
        push_byte(8'h09);
        push_byte(8'h20);
        tick();
        chk("edge_b_accepted", last_rd_cyc - t_a, TO);
        wait_out(1, 40);
        chk("edge_no_ferr", ferr_cnt, f0);
        got = outq.pop_front();
        chk("edge_result", got, 8'h10);

        // Reset while waiting for the opcode
        r0 = rd_cnt;
        w0 = wr_cnt;
        push_byte(8'h33);
        push_byte(8'h44);
        wait_rd(r0 + 2, 20);
        repeat (3) tick();
        rst_n = 1'b0;
        repeat (2) tick();
        chk("mid_rst_a", alu_a, 0);
        chk("mid_rst_b", alu_b, 0);
        chk("mid_rst_busy", busy, 0);
        rst_n = 1'b1;
        push_frame(8'h0F, 8'h3C, 8'h22);
        wait_out(1, 40);
        repeat (5) tick();
        chk("mid_rst_wr_cnt", wr_cnt, w0 + 1);
        got = outq.pop_front();
        chk("mid_rst_result", got, 8'h0C);

        // Randomized frames with random TX back-pressure
        f0 = ferr_cnt;
        rand_bp = 1;
        for (int f = 0; f < 25; f++) begin
            logic [7:0] a, b, op;
            a  = 8'($urandom);
            b  = 8'($urandom);
            op = 8'h20 + 8'($urandom_range(0, 4));
            expq.push_back(alu_ref(a, b, op));
            push_byte(a);
            repeat ($urandom_range(0, 4)) tick();
            push_byte(b);
            repeat ($urandom_range(0, 4)) tick();
            push_byte(op);
            repeat ($urandom_range(0, 4)) tick();
        end
        wait_out(25, 3000);
        rand_bp = 0;
        tx_full = 1'b0;
        for (int i = 0; i < 25 && outq.size() > 0; i++) begin
            got = outq.pop_front();
            chk($sformatf("rand_result_%0d", i), got, expq[i]);
        end
        chk("rand_no_ferr", ferr_cnt, f0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
